// File: rtl/arb_pkg.sv
// Shared constants, state encodings and a find-first helper for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int ID_W  = 4;
  localparam int CNT_W = 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Lowest set bit wins; returns 0 for an all-zero vector (callers gate on |v).
  function automatic logic [ID_W-1:0] find_first(input logic [N_REQ-1:0] v);
    find_first = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) find_first = i[ID_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dec4to16_en.sv
// Enabled 4-to-16 one-hot decoder, built as a 2-to-4 row select feeding four 2-to-4 column decoders.
// Purely combinational; output is all zeros when en=0.
module dec2to4_en (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

module dec4to16_en (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  logic [3:0] row_en;

  dec2to4_en u_row (
    .sel    (sel[3:2]),
    .en     (en),
    .onehot (row_en)
  );

  for (genvar g = 0; g < 4; g++) begin : g_col
    dec2to4_en u_col (
      .sel    (sel[1:0]),
      .en     (row_en[g]),
      .onehot (onehot[4*g +: 4])
    );
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters: req sampled in IDLE is granted the next cycle, one IDLE gap between grants.
// The holder keeps the grant until done, dropping its req, or MAX_HOLD cycles elapse (timeout pulse on forced release).
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [0:0]       state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W-1:0]    win_id;
  logic               any_req;
  logic               limit_hit;
  logic               rel_normal;
  logic               release_now;

  // Rotate so that requester ptr lands at bit 0, pick the lowest set bit, then undo the rotation.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    win_id  = ptr_q + find_first(req_rot);
    any_req = |req;
  end

  always_comb begin
    limit_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
    rel_normal  = done || !req[gnt_id_q];
    release_now = rel_normal || limit_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (any_req) begin
            gnt_id_q   <= win_id;
            hold_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt_q != CNT_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
          if (release_now) begin
            state_q   <= IDLE;
            ptr_q     <= gnt_id_q + 1'b1;
            // A limit coinciding with done or a req drop counts as a normal release.
            timeout_q <= !rel_normal;
          end else begin
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = (state_q == GRANT);
  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;

  dec4to16_en u_gnt_dec (
    .sel    (gnt_id_q),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter sharing one resource between 16 requesters.
- The winner index is held in a 4-bit register. An enabled 4-to-16 decoder expands that index into a one-hot grant vector.
- The block sits in front of any shared datapath slot (bus, ALU, memory port) and sequences access one requester at a time.
- A hold timeout stops a stuck requester from starving the others.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  16  request vector; bit i = requester i wants the resource
- done  input  1  current holder releases the resource this cycle
- gnt  output  16  one-hot grant; all zeros when no grant
- gnt_id  output  4  index of the current holder; valid only when gnt_valid=1
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1), all of the following immediately:
  - state=IDLE, ptr=0, gnt_id=0, hold_cnt=0.
  - gnt=16'h0000, gnt_valid=0, timeout=0, busy=0.
  - Applies equally mid-grant: the grant is dropped at once, with no timeout pulse.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit scanning ptr, ptr+1, ..., ptr+15 (mod 16). Register it into gnt_id, clear hold_cnt, go to GRANT.
  - Latency: a req sampled at edge k gives gnt_valid=1 after edge k.
- State GRANT:
  - gnt_valid=1 and busy=1.
  - gnt = decoder(gnt_id, en=gnt_valid); exactly one bit is set.
  - hold_cnt increments each cycle and saturates at 255.
  - Release conditions, evaluated each cycle; any one releases:
    - done=1
    - req[gnt_id]=0 (holder abandoned)
    - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
  - On release:
    - ptr <= gnt_id+1 (4-bit wrap: 15 -> 0).
    - Go to IDLE; gnt and gnt_valid are 0 the next cycle.
  - timeout=1 for exactly the cycle after a release caused only by MAX_HOLD. If done=1 or req drop occurs in the same cycle as the limit, it is a normal release and timeout stays 0.
- Gap between grants: one mandatory IDLE cycle between any two grants, including back-to-back requests from different requesters.
- Grant length with MAX_HOLD=N: the grant lasts at most N cycles.
- Stability: changes to req bits other than req[gnt_id] during GRANT are ignored until IDLE.
- Fairness: after a holder is released, it has the lowest priority in the next arbitration.
- done while in IDLE: ignored.
- Outputs gnt, gnt_valid, gnt_id, timeout and busy are registered or decoded directly from registered state. There are no combinational paths from req or done to outputs.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=16 and ID_W=4.
  - State encodings IDLE=1'b0, GRANT=1'b1.
  - Hold counter width CNT_W=8.
- Sub-module dec4to16_en (4-bit in, enable, 16-bit one-hot out):
  - Built hierarchically from two-level 2-to-4 enabled decoders.
  - Instantiated once to produce gnt from gnt_id and gnt_valid.
- The priority scan stays in the top module: a rotate by ptr, a fixed-priority find-first, then an add of ptr back.

Test Plan:
- Reset and single request:
  - rst=1 for 2 cycles: all outputs 0.
  - Release rst, then req=16'h0020: next cycle gnt=16'h0020, gnt_id=5, gnt_valid=1, busy=1.
  - done=1 for one cycle: next cycle gnt=0, busy=0, ptr=6.
- Round-robin rotation:
  - req=16'h8001 held, done pulsed each grant.
  - Grants alternate id 0, 15, 0, 15, with one IDLE cycle between each.
- Wrap and scan order:
  - ptr=14 (after serving id 13), req=16'h0003|16'h4000.
  - Next grant order is 14, 0, 1.
- Timeout (MAX_HOLD=8):
  - req=16'h0100 held, done=0.
  - gnt_valid stays 1 for exactly 8 cycles, then timeout=1 for 1 cycle.
  - id 8 is re-granted after the IDLE cycle.
- Abandon and simultaneous events:
  - Holder id 3 drops req[3] with done=0: release occurs with timeout=0.
  - done=1 in the same cycle as hold_cnt reaches MAX_HOLD-1: timeout=0.
- Async reset mid-grant:
  - Assert rst between clock edges while gnt=16'h0400.
  - gnt=0 and busy=0 before the next edge.
  - After release, req=16'hFFFF grants id 0 (ptr reset to 0).
